button_conditioner: RTL



---
 rtl/button_conditioner_pkg.sv | 26 ++
 rtl/debounce_channel.sv | 100 ++++++++++
 rtl/button_conditioner.sv | 39 +++
 3 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button front end: debounce FSM encoding,
// a constant-width helper and the default 10 ms debounce length at 12 MHz.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int DEBOUNCE_12MHZ = 120000;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser into clk, then a debounce FSM
// that accepts a new level only after DEBOUNCE_CYCLES stable cycles.
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_12MHZ,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw,
  output btn_state_e state,
  output logic       press_strobe,
  output logic       release_strobe
);

  localparam int                CNT_W     = clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic              IDLE_LVL  = ACTIVE_LOW;

  logic             s1;
  logic             s2;
  logic             p;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  btn_state_e       state_nxt;
  logic             press_nxt;
  logic             release_nxt;

  assign p = (s2 != IDLE_LVL);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1             <= IDLE_LVL;
      s2             <= IDLE_LVL;
      state          <= ST_RELEASED;
      cnt            <= '0;
      press_strobe   <= 1'b0;
      release_strobe <= 1'b0;
    end else begin
      s1             <= raw;
      s2             <= s1;
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      press_strobe   <= press_nxt;
      release_strobe <= release_nxt;
    end
  end

  // Counter is cleared on every state change, so it never needs to wrap.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      ST_RELEASED: begin
        if (p) begin
          state_nxt = ST_PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!p) begin
          state_nxt = ST_RELEASED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_PRESSED;
          cnt_nxt   = '0;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!p) begin
          state_nxt = ST_RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (p) begin
          state_nxt = ST_PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = ST_RELEASED;
          cnt_nxt     = '0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_RELEASED;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button front end: independent debounced level plus
// single-cycle press/release strobes for each raw keypad line.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int NUM_BTN         = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_12MHZ,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  btn_state_e chan_state [NUM_BTN];

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_chan (
      .clk           (CLK),
      .rst           (RST),
      .raw           (btn_raw[i]),
      .state         (chan_state[i]),
      .press_strobe  (btn_press[i]),
      .release_strobe(btn_release[i])
    );

    // Level is a pure decode of the state register, so it flips on the
    // same edge that launches the matching strobe.
    assign btn_level[i] = (chan_state[i] == ST_PRESSED) ||
                          (chan_state[i] == ST_RELEASE_WAIT);
  end

endmodule
